// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch queue.
//   PC_STEP        : byte increment between sequential instructions
//   PC_ALIGN_BITS  : low address bits forced to zero on every fetch address
//   DEFAULT_XLEN   : default PC / address width
//   DEFAULT_INST_W : default instruction width
//   fetch_entry_t  : {pc, inst} layout of one queue entry at default widths;
//                    the top level packs entries in this same order.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_STEP        = 4;
    localparam int PC_ALIGN_BITS  = 2;
    localparam int DEFAULT_XLEN   = 32;
    localparam int DEFAULT_INST_W = 32;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0]   pc;
        logic [DEFAULT_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched {pc, inst} entries.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push       : write wr_data at the tail this cycle
//   pop        : retire the head entry this cycle
//   flush      : empty the queue; has priority over push and pop
//   wr_data    : entry to write
//   rd_data    : head entry (read from registered storage)
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~flush & ~reset;
    assign pop_ok  = pop & ~flush;

    // Storage has no reset; consumers qualify rd_data with count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
// Owns the program counter, issues requests to a synchronous-read
// instruction memory and buffers {pc, inst} pairs in a prefetch queue that
// decode drains over valid/ready. A redirect flushes the queue and the
// in-flight fetch and restarts fetch at the target in the same cycle.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   imem_req/addr     : fetch request and word-aligned address
//   imem_rdata        : instruction, valid one cycle after imem_req
//   redirect_valid    : flush and restart at redirect_target (bits [1:0] ignored)
//   out_valid/ready   : head-of-queue handshake to decode
//   out_pc/out_inst   : head entry (zero when the queue is empty)
//   q_count           : queue occupancy, 0..DEPTH
// Optional macro FETCH_PERF_EN adds perf_fetched, perf_flushed, perf_stall.
// ---------------------------------------------------------------------------
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              INST_W   = DEFAULT_INST_W,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [INST_W-1:0]      imem_rdata,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [INST_W-1:0]      out_inst,
    output logic [$clog2(DEPTH):0] q_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_flushed,
    output logic [31:0]            perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + INST_W;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] inflight_pc_reg;
    logic            inflight_reg;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_rd_data;
    logic            fifo_push;
    logic            fifo_pop;
    logic            issue;
    logic [CW:0]     demand;
    logic            unused_target_bits;

    assign unused_target_bits = ^redirect_target[PC_ALIGN_BITS-1:0];
    assign redirect_pc = {redirect_target[XLEN-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};

    assign out_valid = (fifo_count != '0);
    assign fifo_pop  = out_valid & out_ready & ~redirect_valid;

    // Entries committed after this cycle if we issue now: queued plus the
    // response landing this cycle, minus what decode takes. Keeping this
    // below DEPTH guarantees every response has a free slot on arrival.
    assign demand = {1'b0, fifo_count} + (CW+1)'(inflight_reg) - (CW+1)'(fifo_pop);
    assign issue  = ~reset & (redirect_valid | (demand < (CW+1)'(DEPTH)));

    assign imem_req  = issue;
    assign imem_addr = redirect_valid ? redirect_pc : fetch_pc_reg;

    // A redirect cancels the response returning this cycle.
    assign fifo_push = inflight_reg & ~redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= imem_addr;
                fetch_pc_reg    <= imem_addr + XLEN'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (redirect_valid),
        .wr_data ({inflight_pc_reg, imem_rdata}),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    // Storage is not reset, so the head is masked while the queue is empty.
    assign out_pc   = out_valid ? fifo_rd_data[EW-1:INST_W] : '0;
    assign out_inst = out_valid ? fifo_rd_data[INST_W-1:0]  : '0;
    assign q_count  = fifo_count;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_flushed_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_reg <= '0;
            perf_flushed_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (fifo_push) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed_reg <= perf_flushed_reg + 32'(fifo_count) + 32'(inflight_reg);
            end
            if ((fifo_count == CW'(DEPTH)) && !out_ready) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_flushed = perf_flushed_reg;
    assign perf_stall   = perf_stall_reg;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
// Directed bench for fetch_queue_unit. A second instance with
// RESET_PC=0xFFFFFFF8 covers PC wrap-around. The instruction memory model
// returns addr ^ 0xA5A5A5A5 one cycle after each request.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  q_count;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_out_valid;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_inst;
    logic [2:0]  w_q_count;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stall;
    logic [31:0] w_perf_fetched, w_perf_flushed, w_perf_stall;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata   <= imem_addr ^ KEY;
    always @(posedge clk) w_imem_rdata <= w_imem_addr ^ KEY;

    fetch_queue_unit #(.XLEN(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .q_count(q_count)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
    );

    fetch_queue_unit #(.XLEN(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_pc(w_out_pc), .out_inst(w_out_inst), .q_count(w_q_count)
`ifdef FETCH_PERF_EN
        , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed), .perf_stall(w_perf_stall)
`endif
    );

    // A push must never land in a full queue.
    always @(negedge clk) begin
        if (!reset && dut.fifo_push) begin
            n_total++;
            if (q_count === 3'(DEPTH)) $display("FAIL push_into_full q_count=%0d required<%0d", q_count, DEPTH);
            else n_pass++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset asserted across two rising edges; the caller releases it.
    task automatic do_reset();
        next_cycle();
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        next_cycle();
        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        next_cycle();
        @(negedge clk);
        n_total++; if (q_count !== 3'd0) $display("FAIL reset_q_count got=%0d exp=0", q_count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc got=%h exp=0", out_pc); else n_pass++;
        n_total++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst got=%h exp=0", out_inst); else n_pass++;
        next_cycle();
        reset = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL reset_first_fetch req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            reset = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i))
                $display("FAIL stream_req cyc=%0d req=%b addr=%h exp addr=%h", i, imem_req, imem_addr, 32'(4*i)); else n_pass++;
            n_total++; if (out_valid !== (i >= 2))
                $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, out_valid, (i >= 2)); else n_pass++;
            if (i >= 2) begin
                n_total++; if (out_pc !== 32'(4*(i-2)) || out_inst !== (32'(4*(i-2)) ^ KEY))
                    $display("FAIL stream_head cyc=%0d pc=%h inst=%h exp pc=%h", i, out_pc, out_inst, 32'(4*(i-2))); else n_pass++;
            end
        end
    endtask

    // Continues from the state test_stream leaves behind (head 28 just popped).
    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            out_ready = 1'b0;
            @(negedge clk);
            n_total++; if (q_count !== ((i < 3) ? 3'(i+1) : 3'd4))
                $display("FAIL bp_q_count cyc=%0d got=%0d exp=%0d", i, q_count, (i < 3) ? i+1 : 4); else n_pass++;
            n_total++; if (imem_req !== (i < 2))
                $display("FAIL bp_imem_req cyc=%0d got=%b exp=%b", i, imem_req, (i < 2)); else n_pass++;
            n_total++; if (out_valid !== 1'b1 || out_pc !== 32'd32)
                $display("FAIL bp_head cyc=%0d valid=%b pc=%h exp pc=20", i, out_valid, out_pc); else n_pass++;
        end
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            out_ready = 1'b1;
            @(negedge clk);
            n_total++; if (out_valid !== 1'b1 || out_pc !== 32'(32 + 4*k) || out_inst !== (32'(32 + 4*k) ^ KEY))
                $display("FAIL bp_release k=%0d valid=%b pc=%h exp pc=%h", k, out_valid, out_pc, 32'(32 + 4*k)); else n_pass++;
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            reset = 1'b0;
            redirect_valid  = (i == 4);
            redirect_target = 32'h102;
            out_ready = (i >= 5);
            @(negedge clk);
            if (i == 4) begin
                n_total++; if (q_count !== 3'd3) $display("FAIL redir_pre_count got=%0d exp=3", q_count); else n_pass++;
                n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
                    $display("FAIL redir_addr req=%b addr=%h exp addr=100", imem_req, imem_addr); else n_pass++;
            end
            if (i == 5) begin
                n_total++; if (q_count !== 3'd0) $display("FAIL redir_flush got=%0d exp=0", q_count); else n_pass++;
`ifdef FETCH_PERF_EN
                n_total++; if (perf_flushed !== 32'd4) $display("FAIL perf_flushed got=%0d exp=4", perf_flushed); else n_pass++;
                n_total++; if (perf_fetched !== 32'd3) $display("FAIL perf_fetched got=%0d exp=3", perf_fetched); else n_pass++;
`endif
            end
            if (i >= 5) begin
                n_total++; if (out_valid !== (i >= 6))
                    $display("FAIL redir_valid cyc=%0d got=%b exp=%b", i, out_valid, (i >= 6)); else n_pass++;
            end
            if (i >= 6) begin
                n_total++; if (out_pc !== 32'(32'h100 + 4*(i-6)) || out_inst !== (32'(32'h100 + 4*(i-6)) ^ KEY))
                    $display("FAIL redir_head cyc=%0d pc=%h exp=%h", i, out_pc, 32'(32'h100 + 4*(i-6))); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            reset = 1'b0; out_ready = 1'b1;
            redirect_valid  = (i == 3) || (i == 4);
            redirect_target = (i == 3) ? 32'h200 : 32'h300;
            @(negedge clk);
            if (i == 3) begin
                n_total++; if (imem_addr !== 32'h200) $display("FAIL b2b_addr0 got=%h exp=200", imem_addr); else n_pass++;
            end
            if (i == 4) begin
                n_total++; if (imem_addr !== 32'h300) $display("FAIL b2b_addr1 got=%h exp=300", imem_addr); else n_pass++;
            end
            if (i >= 4) begin
                n_total++; if (out_valid !== (i >= 6))
                    $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, out_valid, (i >= 6)); else n_pass++;
            end
            if (i >= 6) begin
                n_total++; if (out_pc !== 32'(32'h300 + 4*(i-6)))
                    $display("FAIL b2b_head cyc=%0d pc=%h exp=%h", i, out_pc, 32'(32'h300 + 4*(i-6))); else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            reset = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            if (i >= 2) begin
                e = 32'hFFFFFFF8 + 32'(4*(i-2));
                n_total++; if (w_out_valid !== 1'b1 || w_out_pc !== e || w_out_inst !== (e ^ KEY))
                    $display("FAIL wrap_head cyc=%0d valid=%b pc=%h exp=%h", i, w_out_valid, w_out_pc, e); else n_pass++;
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            reset = (i == 6); out_ready = 1'b1;
            @(negedge clk);
            if (i == 6) begin
                n_total++; if (imem_req !== 1'b0) $display("FAIL mid_req_in_reset got=%b exp=0", imem_req); else n_pass++;
            end
            if (i == 7) begin
                n_total++; if (out_valid !== 1'b0 || q_count !== 3'd0)
                    $display("FAIL mid_cleared valid=%b q_count=%0d exp 0/0", out_valid, q_count); else n_pass++;
                n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
                    $display("FAIL mid_restart req=%b addr=%h exp addr=0", imem_req, imem_addr); else n_pass++;
`ifdef FETCH_PERF_EN
                n_total++; if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0 || perf_stall !== 32'd0)
                    $display("FAIL mid_perf fetched=%0d flushed=%0d stall=%0d exp 0", perf_fetched, perf_flushed, perf_stall); else n_pass++;
`endif
            end
            if (i == 8) begin
                n_total++; if (out_valid !== 1'b0) $display("FAIL mid_stale got valid=%b pc=%h exp valid=0", out_valid, out_pc); else n_pass++;
            end
            if (i == 9) begin
                n_total++; if (out_valid !== 1'b1 || out_pc !== 32'h0)
                    $display("FAIL mid_first_pc valid=%b pc=%h exp pc=0", out_valid, out_pc); else n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
